// File: rtl/chmu_pkg.sv
// Shared types and helpers for the CHMU access front-end.
package chmu_pkg;

  typedef enum logic [1:0] {
    OFF  = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    RDWR = 2'd3
  } chmu_mode_e;

  localparam int unsigned CHMU_PAGE_W = 21;

  typedef struct packed {
    logic                   is_write;
    logic [CHMU_PAGE_W-1:0] page;
  } chmu_rec_t;

  localparam int CHAN_RD = 0;
  localparam int CHAN_WR = 1;

  // Bit CHAN_RD enables AR capture, bit CHAN_WR enables AW capture.
  function automatic logic [1:0] mode_enables(input chmu_mode_e mode);
    logic [1:0] en;
    case (mode)
      OFF:     en = 2'b00;
      RD:      en = 2'b01;
      WR:      en = 2'b10;
      RDWR:    en = 2'b11;
      default: en = 2'b00;
    endcase
    return en;
  endfunction

endpackage

// File: rtl/chmu_addr_fifo.sv
// Synchronous FIFO with wrap-bit pointers; a push on a full FIFO is accepted
// only when a pop frees a slot in the same cycle.
module chmu_addr_fifo
  import chmu_pkg::*;
#(
  parameter int WIDTH = 21,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             push_ok_s, pop_ok_s;
  logic [WIDTH-1:0] mem_q [DEPTH];

  always_comb begin
    empty     = (wr_ptr_q == rd_ptr_q);
    full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    pop_ok_s  = pop & ~empty;
    push_ok_s = push & (~full | pop_ok_s);
    head      = mem_q[rd_ptr_q[AW-1:0]];
    if (push_ok_s) begin
      wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_ok_s) begin
      rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= {(AW+1){1'b0}};
      rd_ptr_q <= {(AW+1){1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: the pointers alone decide what is valid.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_q[wr_ptr_q[AW-1:0]] <= push_data;
    end
  end

endmodule

// File: rtl/chmu_access_frontend.sv
// CHMU capture front-end: filters and samples AR/AW beats, buffers page
// addresses per channel and round-robin merges them into one record stream.
module chmu_access_frontend
  import chmu_pkg::*;
#(
  parameter int ADDR_SIZE  = 33,
  parameter int DATA_SIZE  = 21,
  parameter int FIFO_DEPTH = 16,
  parameter int SAMPLE_W   = 4,
  parameter int DROP_CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  ar_valid,
  input  logic                  ar_ready,
  input  logic [ADDR_SIZE-1:0]  ar_addr,
  input  logic                  aw_valid,
  input  logic                  aw_ready,
  input  logic [ADDR_SIZE-1:0]  aw_addr,
  input  logic [ADDR_SIZE-1:0]  csr_addr_lb,
  input  logic [ADDR_SIZE-1:0]  csr_addr_ub,
  input  logic [1:0]            csr_mode,
  input  logic [SAMPLE_W-1:0]   csr_sample_shift,
  output logic                  out_valid,
  output logic [DATA_SIZE-1:0]  out_addr,
  output logic                  out_is_write,
  input  logic                  out_ready,
  output logic [DROP_CNT_W-1:0] drop_cnt,
  input  logic                  drop_cnt_clr
);

  localparam int CNT_W = 2 ** SAMPLE_W;

  typedef struct packed {
    logic                 is_write;
    logic [DATA_SIZE-1:0] page;
  } rec_t;

  logic [ADDR_SIZE-1:0]       lb_q, ub_q;
  chmu_mode_e                 mode_q;
  logic [SAMPLE_W-1:0]        shift_q;
  logic [1:0][CNT_W-1:0]      cnt_q, cnt_d;
  logic [1:0][CNT_W:0]        inc_s;
  logic [CNT_W:0]             lim_s;
  logic [1:0][ADDR_SIZE-1:0]  addr_s;
  logic [1:0][DATA_SIZE-1:0]  head_s;
  logic [1:0]                 hs_s, en_s, beat_s, keep_s;
  logic [1:0]                 push_s, drop_s, pop_s, gnt_s, full_s, empty_s;
  logic                       load_s, both_s;
  logic                       rr_q, rr_d;
  logic                       out_valid_q, out_valid_d;
  rec_t                       out_q, out_d;
  logic [DROP_CNT_W-1:0]      drop_cnt_q, drop_cnt_d;
  logic [DROP_CNT_W:0]        drop_sum_s;

  // Beat qualification against the shadowed CSRs, plus 1-in-2^shift sampling.
  always_comb begin
    hs_s[CHAN_RD]   = ar_valid & ar_ready;
    hs_s[CHAN_WR]   = aw_valid & aw_ready;
    addr_s[CHAN_RD] = ar_addr;
    addr_s[CHAN_WR] = aw_addr;
    en_s            = mode_enables(mode_q);
    lim_s           = {{CNT_W{1'b0}}, 1'b1} << shift_q;
    beat_s          = 2'b00;
    keep_s          = 2'b00;
    inc_s           = {(2*(CNT_W+1)){1'b0}};
    cnt_d           = cnt_q;
    for (int c = 0; c < 2; c++) begin
      beat_s[c] = hs_s[c] & en_s[c] & (addr_s[c] >= lb_q) & (addr_s[c] <= ub_q);
      keep_s[c] = beat_s[c] & (cnt_q[c] == {CNT_W{1'b0}});
      inc_s[c]  = {1'b0, cnt_q[c]} + {{CNT_W{1'b0}}, 1'b1};
      if (!beat_s[c]) begin
        cnt_d[c] = cnt_q[c];
      end else if (inc_s[c] >= lim_s) begin
        cnt_d[c] = {CNT_W{1'b0}};
      end else begin
        cnt_d[c] = inc_s[c][CNT_W-1:0];
      end
    end
  end

  // Arbitration, output register loading, FIFO push/drop decisions.
  always_comb begin
    load_s = ~out_valid_q | out_ready;
    both_s = ~empty_s[CHAN_RD] & ~empty_s[CHAN_WR];
    gnt_s  = 2'b00;
    if (both_s) begin
      gnt_s[CHAN_WR] = rr_q;
      gnt_s[CHAN_RD] = ~rr_q;
    end else if (!empty_s[CHAN_RD]) begin
      gnt_s[CHAN_RD] = 1'b1;
    end else if (!empty_s[CHAN_WR]) begin
      gnt_s[CHAN_WR] = 1'b1;
    end else begin
      gnt_s = 2'b00;
    end
    pop_s = gnt_s & {load_s, load_s};
    rr_d  = (load_s & both_s) ? ~rr_q : rr_q;

    out_valid_d = out_valid_q;
    out_d       = out_q;
    if (load_s) begin
      out_valid_d = |gnt_s;
      if (gnt_s[CHAN_WR]) begin
        out_d = '{is_write: 1'b1, page: head_s[CHAN_WR]};
      end else if (gnt_s[CHAN_RD]) begin
        out_d = '{is_write: 1'b0, page: head_s[CHAN_RD]};
      end else begin
        out_d = out_q;
      end
    end else begin
      out_valid_d = out_valid_q;
    end

    // A full FIFO still takes the beat when the same cycle pops it.
    push_s = keep_s & (~full_s | pop_s);
    drop_s = keep_s & full_s & ~pop_s;

    drop_sum_s = {1'b0, drop_cnt_q} + {{DROP_CNT_W{1'b0}}, drop_s[CHAN_RD]}
               + {{DROP_CNT_W{1'b0}}, drop_s[CHAN_WR]};
    if (drop_cnt_clr) begin
      drop_cnt_d = {DROP_CNT_W{1'b0}};
    end else if (drop_sum_s[DROP_CNT_W]) begin
      drop_cnt_d = {DROP_CNT_W{1'b1}};
    end else begin
      drop_cnt_d = drop_sum_s[DROP_CNT_W-1:0];
    end
  end

  for (genvar g = 0; g < 2; g++) begin : g_chan
    chmu_addr_fifo #(
      .WIDTH (DATA_SIZE),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk       (clk),
      .rstn      (rstn),
      .push      (push_s[g]),
      .push_data (addr_s[g][ADDR_SIZE-1 -: DATA_SIZE]),
      .pop       (pop_s[g]),
      .full      (full_s[g]),
      .empty     (empty_s[g]),
      .head      (head_s[g])
    );
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      lb_q        <= {ADDR_SIZE{1'b0}};
      ub_q        <= {ADDR_SIZE{1'b0}};
      mode_q      <= OFF;
      shift_q     <= {SAMPLE_W{1'b0}};
      cnt_q       <= {(2*CNT_W){1'b0}};
      rr_q        <= 1'b0;
      out_valid_q <= 1'b0;
      out_q       <= '{is_write: 1'b0, page: {DATA_SIZE{1'b0}}};
      drop_cnt_q  <= {DROP_CNT_W{1'b0}};
    end else begin
      lb_q        <= csr_addr_lb;
      ub_q        <= csr_addr_ub;
      mode_q      <= chmu_mode_e'(csr_mode);
      shift_q     <= csr_sample_shift;
      cnt_q       <= cnt_d;
      rr_q        <= rr_d;
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign out_addr     = out_q.page;
  assign out_is_write = out_q.is_write;
  assign drop_cnt     = drop_cnt_q;

endmodule

// File: tb/tb_chmu_access_frontend.sv
// Scenario bench for chmu_access_frontend: expected records are queued as
// beats are driven and compared when the DUT hands them over.
module tb_chmu_access_frontend;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        ar_valid = 1'b0, ar_ready = 1'b0;
  logic [32:0] ar_addr = 33'h0;
  logic        aw_valid = 1'b0, aw_ready = 1'b0;
  logic [32:0] aw_addr = 33'h0;
  logic [32:0] csr_addr_lb = 33'h0, csr_addr_ub = 33'h0;
  logic [1:0]  csr_mode = 2'd0;
  logic [3:0]  csr_sample_shift = 4'd0;
  logic        out_valid;
  logic [20:0] out_addr;
  logic        out_is_write;
  logic        out_ready = 1'b0;
  logic [15:0] drop_cnt;
  logic        drop_cnt_clr = 1'b0;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [21:0] exp_q [$];
  logic [21:0] exp_rec;

  chmu_access_frontend dut (
    .clk              (clk),
    .rstn             (rstn),
    .ar_valid         (ar_valid),
    .ar_ready         (ar_ready),
    .ar_addr          (ar_addr),
    .aw_valid         (aw_valid),
    .aw_ready         (aw_ready),
    .aw_addr          (aw_addr),
    .csr_addr_lb      (csr_addr_lb),
    .csr_addr_ub      (csr_addr_ub),
    .csr_mode         (csr_mode),
    .csr_sample_shift (csr_sample_shift),
    .out_valid        (out_valid),
    .out_addr         (out_addr),
    .out_is_write     (out_is_write),
    .out_ready        (out_ready),
    .drop_cnt         (drop_cnt),
    .drop_cnt_clr     (drop_cnt_clr)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic drive(input logic arv, input logic [32:0] ara,
                       input logic awv, input logic awr, input logic [32:0] awa);
    ar_valid = arv; ar_ready = arv; ar_addr = ara;
    aw_valid = awv; aw_ready = awr; aw_addr = awa;
  endtask

  task automatic set_csr(input logic [32:0] lb, input logic [32:0] ub,
                         input logic [1:0] m, input logic [3:0] s);
    csr_addr_lb = lb; csr_addr_ub = ub; csr_mode = m; csr_sample_shift = s;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #3;
    n_checks++;
    if (out_valid !== 1'b0 || out_addr !== 21'h0 || out_is_write !== 1'b0 || drop_cnt !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_state: got v=%b a=%h w=%b d=%0d, required 0/0/0/0",
               out_valid, out_addr, out_is_write, drop_cnt);
    end
    @(posedge clk); #1;
    rstn = 1'b1;
  endtask

  task automatic test_window();
    logic [32:0] a [4];
    int got = 0;
    a[0] = 33'h0FFF; a[1] = 33'h1000; a[2] = 33'h1FFF; a[3] = 33'h2000;
    out_ready = 1'b1;
    set_csr(33'h1000, 33'h1FFF, 2'd1, 4'd0);
    for (int cyc = 0; cyc < 16; cyc++) begin
      @(posedge clk); #1;
      if (cyc < 4) begin
        drive(1'b1, a[cyc], 1'b0, 1'b0, 33'h0);
        if (a[cyc] >= 33'h1000 && a[cyc] <= 33'h1FFF) exp_q.push_back({1'b0, a[cyc][32:12]});
      end else begin
        drive(1'b0, 33'h0, 1'b0, 1'b0, 33'h0);
      end
      @(negedge clk);
      if (out_valid && out_ready) begin
        got++;
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL window_rec: got %h, required no record", {out_is_write, out_addr});
        end else begin
          exp_rec = exp_q.pop_front();
          if ({out_is_write, out_addr} !== exp_rec) begin
            n_fail++; $display("FAIL window_rec: got %h, required %h", {out_is_write, out_addr}, exp_rec);
          end
        end
      end
    end
    n_checks++;
    if (got !== 2) begin n_fail++; $display("FAIL window_count: got %0d, required 2", got); end
  endtask

  task automatic test_sampling();
    int got = 0;
    set_csr(33'h0, 33'h1_FFFF_FFFF, 2'd3, 4'd2);
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(posedge clk); #1;
      if (cyc < 8) begin
        drive(1'b1, 33'(cyc + 3) << 12, 1'b1, 1'b0, 33'h5000);
        if (cyc % 4 == 0) exp_q.push_back({1'b0, 21'(cyc + 3)});
      end else begin
        drive(1'b0, 33'h0, 1'b0, 1'b0, 33'h0);
      end
      @(negedge clk);
      if (out_valid && out_ready) begin
        got++;
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL sample_rec: got %h, required no record", {out_is_write, out_addr});
        end else begin
          exp_rec = exp_q.pop_front();
          if ({out_is_write, out_addr} !== exp_rec) begin
            n_fail++; $display("FAIL sample_rec: got %h, required %h", {out_is_write, out_addr}, exp_rec);
          end
        end
      end
    end
    n_checks++;
    if (got !== 2) begin n_fail++; $display("FAIL sample_count: got %0d, required 2", got); end
  endtask

  task automatic test_back_to_back();
    int got = 0;
    set_csr(33'h0, 33'h1_FFFF_FFFF, 2'd3, 4'd0);
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(posedge clk); #1;
      if (cyc < 4) begin
        drive(1'b1, 33'hA000, 1'b1, 1'b1, 33'hB000);
        exp_q.push_back({1'b0, 21'hA});
        exp_q.push_back({1'b1, 21'hB});
      end else begin
        drive(1'b0, 33'h0, 1'b0, 1'b0, 33'h0);
      end
      @(negedge clk);
      if (out_valid && out_ready) begin
        got++;
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL b2b_rec: got %h, required no record", {out_is_write, out_addr});
        end else begin
          exp_rec = exp_q.pop_front();
          if ({out_is_write, out_addr} !== exp_rec) begin
            n_fail++; $display("FAIL b2b_rec: got %h, required %h", {out_is_write, out_addr}, exp_rec);
          end
        end
      end
    end
    n_checks++;
    if (got !== 8) begin n_fail++; $display("FAIL b2b_count: got %0d, required 8", got); end
    n_checks++;
    if (drop_cnt !== 16'd0) begin n_fail++; $display("FAIL b2b_drops: got %0d, required 0", drop_cnt); end
  endtask

  task automatic test_overflow();
    int got = 0;
    set_csr(33'h0, 33'h1_FFFF_FFFF, 2'd1, 4'd0);
    out_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      drive(1'b1, 33'(i + 16) << 12, 1'b0, 1'b0, 33'h0);
      if (i < 17) exp_q.push_back({1'b0, 21'(i + 16)});
    end
    @(posedge clk); #1;
    drive(1'b1, 33'h99000, 1'b0, 1'b0, 33'h0);
    drop_cnt_clr = 1'b1;
    @(negedge clk);
    n_checks++;
    if (drop_cnt !== 16'd3) begin n_fail++; $display("FAIL ovf_drops: got %0d, required 3", drop_cnt); end
    n_checks++;
    if (out_valid !== 1'b1 || out_addr !== 21'h10) begin
      n_fail++; $display("FAIL ovf_head: got v=%b a=%h, required v=1 a=10", out_valid, out_addr);
    end
    @(posedge clk); #1;
    drive(1'b0, 33'h0, 1'b0, 1'b0, 33'h0);
    drop_cnt_clr = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (drop_cnt !== 16'd0) begin n_fail++; $display("FAIL ovf_clr: got %0d, required 0", drop_cnt); end
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (cyc > 0) begin
        @(posedge clk); #1;
        @(negedge clk);
      end
      if (out_valid && out_ready) begin
        got++;
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL ovf_rec: got %h, required no record", {out_is_write, out_addr});
        end else begin
          exp_rec = exp_q.pop_front();
          if ({out_is_write, out_addr} !== exp_rec) begin
            n_fail++; $display("FAIL ovf_rec: got %h, required %h", {out_is_write, out_addr}, exp_rec);
          end
        end
      end
    end
    n_checks++;
    if (got !== 17) begin n_fail++; $display("FAIL ovf_count: got %0d, required 17", got); end
  endtask

  task automatic test_random_stall();
    int          got = 0;
    int          sent = 0;
    logic        prev_stall = 1'b0;
    logic [21:0] prev_rec = 22'h0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      @(posedge clk); #1;
      out_ready = (cyc >= 220) ? 1'b1 : 1'($urandom_range(0, 1));
      if (cyc % 4 == 0 && sent < 50) begin
        drive(1'b1, {21'(sent + 32), 12'($urandom_range(0, 4095))}, 1'b0, 1'b0, 33'h0);
        exp_q.push_back({1'b0, 21'(sent + 32)});
        sent++;
      end else begin
        drive(1'b0, 33'h0, 1'b0, 1'b0, 33'h0);
      end
      @(negedge clk);
      if (prev_stall) begin
        n_checks++;
        if (out_valid !== 1'b1 || {out_is_write, out_addr} !== prev_rec) begin
          n_fail++;
          $display("FAIL stall_hold: got v=%b rec=%h, required v=1 rec=%h",
                   out_valid, {out_is_write, out_addr}, prev_rec);
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_rec   = {out_is_write, out_addr};
      if (out_valid && out_ready) begin
        got++;
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL stream_rec: got %h, required no record", {out_is_write, out_addr});
        end else begin
          exp_rec = exp_q.pop_front();
          if ({out_is_write, out_addr} !== exp_rec) begin
            n_fail++; $display("FAIL stream_rec: got %h, required %h", {out_is_write, out_addr}, exp_rec);
          end
        end
      end
    end
    n_checks++;
    if (got !== 50) begin n_fail++; $display("FAIL stream_count: got %0d, required 50", got); end
    n_checks++;
    if (drop_cnt !== 16'd0) begin n_fail++; $display("FAIL stream_drops: got %0d, required 0", drop_cnt); end
  endtask

  task automatic test_mid_reset();
    int got = 0;
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      drive(1'b1, 33'(i + 64) << 12, 1'b0, 1'b0, 33'h0);
    end
    @(posedge clk); #1;
    drive(1'b0, 33'h0, 1'b0, 1'b0, 33'h0);
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b1) begin n_fail++; $display("FAIL rst_pre: got v=%b, required 1", out_valid); end
    #2 rstn = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || drop_cnt !== 16'd0) begin
      n_fail++; $display("FAIL rst_async: got v=%b d=%0d, required v=0 d=0", out_valid, drop_cnt);
    end
    @(posedge clk); #1;
    rstn = 1'b1;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 24; cyc++) begin
      @(posedge clk); #1;
      if (cyc == 12) begin
        drive(1'b1, 33'h7000, 1'b0, 1'b0, 33'h0);
        exp_q.push_back({1'b0, 21'h7});
      end else begin
        drive(1'b0, 33'h0, 1'b0, 1'b0, 33'h0);
      end
      @(negedge clk);
      if (out_valid && out_ready) begin
        got++;
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL rst_stale: got %h, required no record", {out_is_write, out_addr});
        end else begin
          exp_rec = exp_q.pop_front();
          if ({out_is_write, out_addr} !== exp_rec) begin
            n_fail++; $display("FAIL rst_rec: got %h, required %h", {out_is_write, out_addr}, exp_rec);
          end
        end
      end
    end
    n_checks++;
    if (got !== 1) begin n_fail++; $display("FAIL rst_count: got %0d, required 1", got); end
    n_checks++;
    if (drop_cnt !== 16'd0) begin n_fail++; $display("FAIL rst_drops: got %0d, required 0", drop_cnt); end
  endtask

  initial begin
    test_reset();
    test_window();
    test_sampling();
    test_back_to_back();
    test_overflow();
    test_random_stall();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
